muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; SHALL be a power of two, at least 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  execute-stage request to begin the operation selected by op.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srca, srcb  input  WIDTH  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 hienE, loenE  input  1 each  direct write of srca into HI / LO (MTHI/MTLO).
REQ-008 abort  input  1  cancels an in-flight operation.
REQ-009 hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-010 busy  output  1  operation in flight; drives pipeline stall.
REQ-011 done  output  1  one-cycle pulse when HI/LO receive a result.

Function
REQ-012 States SHALL be IDLE, RUN, FIXUP; busy SHALL equal (state != IDLE).
REQ-013 In IDLE with start=1 at an edge: latch operand magnitudes, op and result signs; enter RUN with iteration count 0.
REQ-014 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle for exactly WIDTH cycles, then enter FIXUP.
REQ-015 FIXUP SHALL apply sign correction, write HI/LO, return to IDLE and assert done for the following cycle; busy is high for WIDTH+1 cycles per operation.
REQ-016 Multiply: {hi,lo} SHALL equal the full 2*WIDTH product, signed for MULT, unsigned for MULTU.
REQ-017 Divide: lo SHALL be the quotient truncated toward zero, hi the remainder; remainder sign SHALL equal dividend sign.
REQ-018 Divide by zero (DIV or DIVU): lo SHALL be all ones and hi SHALL be srca; latency unchanged.
REQ-019 DIV of most-negative value by -1: lo SHALL be most-negative value, hi SHALL be 0.
REQ-020 start while busy SHALL be ignored; the requester must hold start until busy is low.
REQ-021 In IDLE with start=0: hienE SHALL load hi<=srca, loenE SHALL load lo<=srca at the next edge; both may be asserted together.
REQ-022 start and hienE/loenE together in IDLE: start SHALL win and the direct writes SHALL be dropped.
REQ-023 hienE/loenE while busy SHALL be ignored.
REQ-024 abort while busy SHALL return to IDLE at the next edge, leave hi/lo unchanged and suppress done; abort in IDLE SHALL have no effect and SHALL block a same-cycle start.
REQ-025 hi/lo SHALL change only at FIXUP completion, direct writes, or reset.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0 immediately, including mid-operation.
REQ-027 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU SHALL compute in a single-cycle multiplier, write HI/LO at the edge after start, pulse done one cycle later, and busy SHALL be high one cycle; divides unaffected.
REQ-029 Without MULDIV_FAST_MUL_EN, multiplies SHALL use the iterative RUN/FIXUP path with WIDTH+1 cycle latency.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op encoding enum and the state enum.
REQ-031 Sign/magnitude pre-conversion and result fixup SHALL live in combinational sub-module muldiv_sign_fix; the FSM, counter and datapath registers stay in muldiv_unit.

Verification
REQ-032 MULT 0xFFFFFFFD x 0x00000007 -> after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, single done pulse.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-035 Second start while busy -> ignored, first result intact; idle hienE with srca=0x00001234 -> hi=0x00001234 next edge, lo unchanged.
REQ-036 abort on cycle 10 of a DIV -> IDLE next edge, no done, hi/lo unchanged; reset on cycle 5 -> hi=lo=0, busy=0 immediately.
REQ-037 With MULDIV_FAST_MUL_EN, MULTU 3 x 5 -> lo=0x0000000F, hi=0 one edge after start, busy one cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_e;

    function automatic logic isSignedOp(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    import muldiv_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             hienE;
    logic             loenE;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, srca, srcb, hienE, loenE, abort,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, srca, srcb, hienE, loenE, abort,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes and result signs on the way in,
// two's-complement correction of the unsigned core result on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] magA,
    output logic [WIDTH-1:0] magB,
    output logic             resNeg,
    output logic             remNeg,
    input  logic             isMul,
    input  logic             resNegIn,
    input  logic             remNegIn,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    output logic [WIDTH-1:0] hiRes,
    output logic [WIDTH-1:0] loRes
);
    logic             signA;
    logic             signB;
    logic [2*WIDTH-1:0] prod;

    assign signA = isSignedOp(op) && srca[WIDTH-1];
    assign signB = isSignedOp(op) && srcb[WIDTH-1];
    assign magA  = signA ? -srca : srca;
    assign magB  = signB ? -srcb : srcb;
    // A zero divisor leaves quotient all ones and remainder = |dividend|; keeping the
    // quotient positive and restoring the dividend sign reproduces srca in HI.
    assign resNeg = (signA ^ signB) && !(op[1] && (srcb == '0));
    assign remNeg = signA;

    assign prod = {accHi, accLo};

    always_comb begin
        hiRes = accHi;
        loRes = accLo;
        if (isMul) begin
            if (resNegIn) begin
                {hiRes, loRes} = -prod;
            end
        end else begin
            if (resNegIn) begin
                loRes = -accLo;
            end
            if (remNegIn) begin
                hiRes = -accHi;
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO, one step per cycle.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             stateReg, stateNext;
    op_e                opReg;
    logic [CW-1:0]      cntReg;
    logic [WIDTH-1:0]   accHiReg, accLoReg, operandReg, hiReg, loReg;
    logic               resNegReg, remNegReg, doneReg;
    logic [WIDTH-1:0]   magA, magB, hiFix, loFix;
    logic               resNeg, remNeg;
    logic               startOk, lastIter;
    logic [WIDTH:0]     addSum, divShift, divDiff;
    logic               fastStart, fastReg;
    logic [2*WIDTH-1:0] fastProd;

    assign startOk  = bus.start && !bus.abort;
    assign lastIter = (cntReg == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] extA, extB;
    assign extA      = {{WIDTH{isSignedOp(bus.op) && bus.srca[WIDTH-1]}}, bus.srca};
    assign extB      = {{WIDTH{isSignedOp(bus.op) && bus.srcb[WIDTH-1]}}, bus.srcb};
    assign fastProd  = extA * extB;
    assign fastStart = startOk && !bus.op[1];

    // Marks the single busy cycle of a fast multiply so FIXUP does not rewrite HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fastReg <= 1'b0;
        end else if (stateReg == IDLE) begin
            fastReg <= fastStart;
        end
    end
`else
    assign fastProd  = '0;
    assign fastStart = 1'b0;
    assign fastReg   = 1'b0;
`endif

    // Multiply: shift-add on {accHi, accLo}; divide: restoring subtract with quotient shifted into accLo.
    assign addSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, operandReg} : '0);
    assign divShift = {accHiReg, accLoReg[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, operandReg};

    muldiv_sign_fix #(.WIDTH(WIDTH)) signFix (
        .op       (bus.op),
        .srca     (bus.srca),
        .srcb     (bus.srcb),
        .magA     (magA),
        .magB     (magB),
        .resNeg   (resNeg),
        .remNeg   (remNeg),
        .isMul    (!opReg[1]),
        .resNegIn (resNegReg),
        .remNegIn (remNegReg),
        .accHi    (accHiReg),
        .accLo    (accLoReg),
        .hiRes    (hiFix),
        .loRes    (loFix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE:    if (startOk) stateNext = fastStart ? FIXUP : RUN;
            RUN:     if (bus.abort) stateNext = IDLE;
                     else if (lastIter) stateNext = FIXUP;
            FIXUP:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg      <= OP_MULT;
            cntReg     <= '0;
            accHiReg   <= '0;
            accLoReg   <= '0;
            operandReg <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            resNegReg  <= 1'b0;
            remNegReg  <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (stateReg)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.abort) begin
                            opReg      <= bus.op;
                            cntReg     <= '0;
                            accHiReg   <= '0;
                            operandReg <= bus.op[1] ? magB : magA;
                            accLoReg   <= bus.op[1] ? magA : magB;
                            resNegReg  <= resNeg;
                            remNegReg  <= remNeg;
                            if (fastStart) begin
                                hiReg <= fastProd[2*WIDTH-1:WIDTH];
                                loReg <= fastProd[WIDTH-1:0];
                            end
                        end
                    end else begin
                        if (bus.hienE) hiReg <= bus.srca;
                        if (bus.loenE) loReg <= bus.srca;
                    end
                end
                RUN: begin
                    if (!bus.abort) begin
                        cntReg <= cntReg + 1'b1;
                        if (opReg[1]) begin
                            accHiReg <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
                            accLoReg <= {accLoReg[WIDTH-2:0], ~divDiff[WIDTH]};
                        end else begin
                            accHiReg <= addSum[WIDTH:1];
                            accLoReg <= {addSum[0], accLoReg[WIDTH-1:1]};
                        end
                    end
                end
                FIXUP: begin
                    if (!bus.abort) begin
                        if (!fastReg) begin
                            hiReg <= hiFix;
                            loReg <= loFix;
                        end
                        doneReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
    assign bus.busy = (stateReg != IDLE);
    assign bus.done = doneReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed literal vectors.
`timescale 1ns/1ps
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic rules.
    function automatic logic [63:0] refResult(input op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, qb;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return sa * sb;
            end
            OP_MULTU: begin
                ua = {32'h0, a};
                ub = {32'h0, b};
                return ua * ub;
            end
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                qa = a;
                qb = b;
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycle model: a busy countdown plus pending result.
    int          remain    = 0;
    logic [63:0] pend      = '0;
    bit          pendWrite = 0;
    logic [31:0] expHi     = '0;
    logic [31:0] expLo     = '0;
    bit          expDone   = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            remain = 0; expHi = '0; expLo = '0; expDone = 0; pendWrite = 0;
        end else begin
            expDone = 0;
            if (remain > 0) begin
                if (bus.abort) begin
                    remain = 0;
                end else begin
                    remain--;
                    if (remain == 0) begin
                        if (pendWrite) {expHi, expLo} = pend;
                        expDone = 1;
                    end
                end
            end else if (bus.start) begin
                if (!bus.abort) begin
                    pend = refResult(bus.op, bus.srca, bus.srcb);
                    pendWrite = 1;
                    remain = W + 1;
`ifdef MULDIV_FAST_MUL_EN
                    if (!bus.op[1]) begin
                        {expHi, expLo} = pend;
                        pendWrite = 0;
                        remain = 1;
                    end
`endif
                end
            end else begin
                if (bus.hienE) expHi = bus.srca;
                if (bus.loenE) expLo = bus.srca;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("cmp_hi", bus.hi, expHi);
            check("cmp_lo", bus.lo, expLo);
            check("cmp_busy", 32'(bus.busy), 32'(remain > 0));
            check("cmp_done", 32'(bus.done), 32'(expDone));
        end
    end

    task automatic waitDone(input int limit, output int busyCycles, output bit got);
        busyCycles = 0;
        got = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hienE = 1'b0;
            bus.loenE = 1'b0;
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] wantHi, input logic [31:0] wantLo);
        int bc;
        bit got;
        int wantBc;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        waitDone(100, bc, got);
        wantBc = W + 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) wantBc = 1;
`endif
        check({name, "_done"}, 32'(got), 32'd1);
        check({name, "_hi"}, bus.hi, wantHi);
        check({name, "_lo"}, bus.lo, wantLo);
        check({name, "_busycyc"}, 32'(bc), 32'(wantBc));
        @(negedge clk);
        check({name, "_pulse"}, 32'(bus.done), 32'd0);
        $display("%s op=%s a=%h b=%h -> hi=%h lo=%h busy=%0d", name, op.name(), a, b, bus.hi, bus.lo, bc);
    endtask

    initial begin
        int bc;
        bit got;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.hienE = 1'b0;
        bus.loenE = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        $display("reset released hi=%h lo=%h", bus.hi, bus.lo);

        runOp("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_zero", OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);

        bus.hienE = 1'b1;
        bus.srca  = 32'h0000_1234;
        @(negedge clk);
        bus.hienE = 1'b0;
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_lo", bus.lo, 32'hFFFF_FFFF);
        $display("mthi srca=%h -> hi=%h lo=%h", 32'h0000_1234, bus.hi, bus.lo);

        bus.hienE = 1'b1;
        bus.loenE = 1'b1;
        bus.srca  = 32'hABCD_0001;
        @(negedge clk);
        bus.hienE = 1'b0;
        bus.loenE = 1'b0;
        check("mthilo_hi", bus.hi, 32'hABCD_0001);
        check("mthilo_lo", bus.lo, 32'hABCD_0001);
        $display("mthi+mtlo srca=%h -> hi=%h lo=%h", 32'hABCD_0001, bus.hi, bus.lo);

        runOp("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        runOp("divu_rem",  OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
        runOp("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        runOp("mult_ext",  OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

        bus.hienE = 1'b1;
        bus.loenE = 1'b1;
        runOp("start_wins", OP_MULTU, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006);

        // Second start plus MTHI while busy must both be ignored.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.srca = 32'd100; bus.srcb = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.srca = 32'd3; bus.srcb = 32'd5; bus.hienE = 1'b1;
        waitDone(100, bc, got);
        check("busy_ign_done", 32'(got), 32'd1);
        check("busy_ign_hi", bus.hi, 32'h0000_0002);
        check("busy_ign_lo", bus.lo, 32'h0000_000E);
        waitDone(40, bc, got);
        check("busy_ign_nosecond", 32'(got), 32'd0);
        check("busy_ign_idle", 32'(bc), 32'd0);
        $display("busy_ignore hi=%h lo=%h", bus.hi, bus.lo);

        // Abort in IDLE blocks a same-cycle start.
        bus.start = 1'b1; bus.abort = 1'b1; bus.op = OP_DIV;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        $display("idle abort+start busy=%0d", bus.busy);

        // Abort on busy cycle 10 of a DIV.
        bus.start = 1'b1; bus.op = OP_DIV; bus.srca = 32'd1000; bus.srcb = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        waitDone(40, bc, got);
        check("abort_nodone", 32'(got), 32'd0);
        check("abort_hi", bus.hi, 32'h0000_0002);
        check("abort_lo", bus.lo, 32'h0000_000E);
        $display("abort div hi=%h lo=%h", bus.hi, bus.lo);

        // Reset on busy cycle 5, asserted between edges.
        bus.start = 1'b1; bus.op = OP_DIV; bus.srca = 32'd1000; bus.srcb = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        $display("mid-op reset hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        runOp("after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000);
        runOp("multu_small", OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
